argmax_row_sequencer: RTL and testbench

- Controller that sequences the GCN classification stage.
- On a start pulse it issues row addresses to the FM×WM×ADJ result memory, one row per cycle, with rd_en.
- Tracks the memory's fixed read latency, computes each row's argmax as data returns, and stores it in a per-row answer register file.
- Pulses done when every row is resolved. Sits between the aggregation result buffer and the top-level result/readout logic.

---
 rtl/argmax_row_sequencer.sv | 135 +++++++++++++
 tb/tb_argmax_row_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/argmax_row_sequencer.sv
// Issues one row read per cycle, follows the fixed memory read latency and records each row's argmax.
// Define ARGMAX_SIGNED_EN to compare elements as two's-complement signed values (unsigned otherwise).
module argmax_row_sequencer #(
    parameter int DOT_PROD_WIDTH    = 16,
    parameter int FM_WM_COLS        = 3,
    parameter int FEATURE_ROWS      = 6,
    parameter int MAX_ADDRESS_WIDTH = 2,
    parameter int RD_LATENCY        = 1,
    parameter int ROW_WIDTH         = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic                                             start,
    input  logic [FM_WM_COLS-1:0][DOT_PROD_WIDTH-1:0]        fm_wm_adj_out,
    output logic [ROW_WIDTH-1:0]                             fm_wm_adj_row,
    output logic                                             rd_en,
    output logic                                             busy,
    output logic                                             done,
    output logic [FEATURE_ROWS-1:0][MAX_ADDRESS_WIDTH-1:0]   max_addi_answer
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [RD_LATENCY-1:0] OLDEST_MASK = RD_LATENCY'(1) << (RD_LATENCY - 1);

    state_t                       state_reg, state_next;
    logic [ROW_WIDTH-1:0]         counter_reg, counter_next;
    logic [RD_LATENCY-1:0]        valid_reg;
    logic [ROW_WIDTH-1:0]         tag_reg [RD_LATENCY];
    logic [MAX_ADDRESS_WIDTH-1:0] answer_reg [FEATURE_ROWS];
    logic [MAX_ADDRESS_WIDTH-1:0] best_idx;
    logic [DOT_PROD_WIDTH-1:0]    best_val;
    logic                         exit_valid;
    logic [ROW_WIDTH-1:0]         exit_tag;
    logic                         pipe_pending;

    assign exit_valid    = valid_reg[RD_LATENCY-1];
    assign exit_tag      = tag_reg[RD_LATENCY-1];
    // Anything still in flight besides the entry returning this cycle keeps us in DRAIN.
    assign pipe_pending  = |(valid_reg & ~OLDEST_MASK);
    assign fm_wm_adj_row = counter_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            counter_reg <= '0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        rd_en        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next   = ISSUE;
                    counter_next = '0;
                end
            end
            ISSUE: begin
                rd_en = 1'b1;
                busy  = 1'b1;
                if (counter_reg == ROW_WIDTH'(FEATURE_ROWS - 1)) begin
                    state_next   = DRAIN;
                    counter_next = '0;
                end else begin
                    counter_next = counter_reg + ROW_WIDTH'(1);
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (!pipe_pending) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Latency pipe: stage 0 takes the issued row, the last stage lines up with returning data.
    generate
        for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_pipe
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    valid_reg[gi] <= 1'b0;
                    tag_reg[gi]   <= '0;
                end else if (gi == 0) begin
                    valid_reg[gi] <= rd_en;
                    tag_reg[gi]   <= counter_reg;
                end else begin
                    valid_reg[gi] <= valid_reg[(gi > 0) ? gi - 1 : 0];
                    tag_reg[gi]   <= tag_reg[(gi > 0) ? gi - 1 : 0];
                end
            end
        end
    endgenerate

    // Strict greater-than scan so ties keep the lowest index.
    always_comb begin
        best_idx = '0;
        best_val = fm_wm_adj_out[0];
        for (int i = 1; i < FM_WM_COLS; i++) begin
`ifdef ARGMAX_SIGNED_EN
            if ($signed(fm_wm_adj_out[i]) > $signed(best_val)) begin
`else
            if (fm_wm_adj_out[i] > best_val) begin
`endif
                best_val = fm_wm_adj_out[i];
                best_idx = MAX_ADDRESS_WIDTH'(i);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < FEATURE_ROWS; gi++) begin : g_answer
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    answer_reg[gi] <= '0;
                end else if (exit_valid && exit_tag == ROW_WIDTH'(gi)) begin
                    answer_reg[gi] <= best_idx;
                end
            end
            assign max_addi_answer[gi] = answer_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_argmax_row_sequencer.sv
// Directed bench: two sequencers (read latency 1 and 3) fed by a shared row table through latency-matched memory models.
module tb_argmax_row_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;

    logic [2:0][15:0] mem_a, mem_b;
    logic [2:0]       row_a, row_b;
    logic             rd_en_a, rd_en_b, busy_a, busy_b, done_a, done_b;
    logic [5:0][1:0]  ans_a, ans_b;

    logic [2:0][15:0] tbl [6];
    logic [3:0]       s1_b, s2_b;   // {valid, row} stages of the latency-3 memory model

    int errors = 0;
    int checks = 0;
    int rd_cnt_a, rd_cnt_b, done_cnt_a, done_cnt_b;
    int exp1 [6];
    int exp2 [6];

    always #5 clk = ~clk;

    argmax_row_sequencer #(.RD_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .start(start), .fm_wm_adj_out(mem_a),
        .fm_wm_adj_row(row_a), .rd_en(rd_en_a), .busy(busy_a), .done(done_a),
        .max_addi_answer(ans_a)
    );

    argmax_row_sequencer #(.RD_LATENCY(3)) dut_b (
        .clk(clk), .reset(reset), .start(start), .fm_wm_adj_out(mem_b),
        .fm_wm_adj_row(row_b), .rd_en(rd_en_b), .busy(busy_b), .done(done_b),
        .max_addi_answer(ans_b)
    );

    // Memory models; junk outside valid cycles must be ignored by the design.
    always @(posedge clk) begin
        mem_a <= rd_en_a ? tbl[row_a] : {16'hFFFF, 16'hFFFF, 16'h0000};
        s1_b  <= {rd_en_b, row_b};
        s2_b  <= s1_b;
        mem_b <= s2_b[3] ? tbl[s2_b[2:0]] : {16'hFFFF, 16'hFFFF, 16'h0000};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(input int r, input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
        tbl[r] = {e2, e1, e0};
    endtask

    task automatic load_table1();
        set_row(0, 1, 5, 2); set_row(1, 9, 3, 4); set_row(2, 0, 0, 7);
        set_row(3, 2, 8, 8); set_row(4, 6, 6, 6); set_row(5, 3, 1, 2);
    endtask

    task automatic check_answers(input string tag, input int exp [6]);
        for (int r = 0; r < 6; r++) begin
            chk($sformatf("%s_a_row%0d", tag, r), 32'(ans_a[r]), 32'(exp[r]));
            chk($sformatf("%s_b_row%0d", tag, r), 32'(ans_b[r]), 32'(exp[r]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        exp1 = '{1, 0, 2, 1, 0, 0};
`ifdef ARGMAX_SIGNED_EN
        exp2 = '{1, 2, 0, 1, 2, 0};
`else
        exp2 = '{0, 2, 0, 1, 2, 0};
`endif
        load_table1();

        // Reset state
        tick(); tick();
        chk("reset_rd_en_a", 32'(rd_en_a), 0);
        chk("reset_row_a", 32'(row_a), 0);
        chk("reset_busy_a", 32'(busy_a), 0);
        chk("reset_done_a", 32'(done_a), 0);
        chk("reset_busy_b", 32'(busy_b), 0);
        chk("reset_ans_a", 32'(ans_a), 0);
        chk("reset_ans_b", 32'(ans_b), 0);
        @(negedge clk);
        reset = 1'b0;

        // Run 1: basic timing for latency 1 and 3
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c <= 10; c++) begin
            chk($sformatf("run1_rd_en_a_c%0d", c), 32'(rd_en_a), 32'(c <= 5));
            chk($sformatf("run1_row_a_c%0d", c), 32'(row_a), (c <= 5) ? 32'(c) : 0);
            chk($sformatf("run1_busy_a_c%0d", c), 32'(busy_a), 32'(c < 7));
            chk($sformatf("run1_done_a_c%0d", c), 32'(done_a), 32'(c == 7));
            chk($sformatf("run1_rd_en_b_c%0d", c), 32'(rd_en_b), 32'(c <= 5));
            chk($sformatf("run1_busy_b_c%0d", c), 32'(busy_b), 32'(c < 9));
            chk($sformatf("run1_done_b_c%0d", c), 32'(done_b), 32'(c == 9));
            if (c == 1) chk("run1_a_row0_before", 32'(ans_a[0]), 0);
            if (c == 2) chk("run1_a_row0_after", 32'(ans_a[0]), 1);
            if (c == 3) chk("run1_b_row0_before", 32'(ans_b[0]), 0);
            if (c == 4) chk("run1_b_row0_after", 32'(ans_b[0]), 1);
            tick();
        end
        check_answers("run1", exp1);

        // Run 2: start re-pulsed in ISSUE and in A's DONE cycle, new data incl. signed row
        set_row(0, 16'hFFFF, 16'h0001, 16'h0000); set_row(1, 4, 4, 5); set_row(2, 7, 2, 7);
        set_row(3, 0, 9, 9); set_row(4, 1, 2, 3); set_row(5, 8, 0, 0);
        rd_cnt_a = 0; rd_cnt_b = 0; done_cnt_a = 0; done_cnt_b = 0;
        start = 1'b1;
        tick();
        for (int c = 0; c <= 15; c++) begin
            start = (c == 2 || c == 7);
            if (rd_en_a) rd_cnt_a++;
            if (rd_en_b) rd_cnt_b++;
            if (done_a) done_cnt_a++;
            if (done_b) done_cnt_b++;
            tick();
        end
        start = 1'b0;
        chk("run2_rd_cycles_a", 32'(rd_cnt_a), 6);
        chk("run2_rd_cycles_b", 32'(rd_cnt_b), 6);
        chk("run2_done_pulses_a", 32'(done_cnt_a), 1);
        chk("run2_done_pulses_b", 32'(done_cnt_b), 1);
        check_answers("run2", exp2);

        // Runs 3/4: start held high gives back-to-back runs
        load_table1();
        start = 1'b1;
        tick();
        for (int c = 0; c <= 24; c++) begin
            if (c == 7) chk("held_done_a_c7", 32'(done_a), 1);
            if (c == 8) begin
                chk("held_idle_row_a", 32'(row_a), 0);
                chk("held_idle_rd_en_a", 32'(rd_en_a), 0);
                chk("held_idle_busy_a", 32'(busy_a), 0);
            end
            if (c == 9) begin
                chk("held_restart_rd_en_a", 32'(rd_en_a), 1);
                chk("held_restart_row_a", 32'(row_a), 0);
            end
            if (c == 10) begin
                chk("held_second_row_a", 32'(row_a), 1);
                chk("held_idle_rd_en_b", 32'(rd_en_b), 0);
                chk("held_idle_busy_b", 32'(busy_b), 0);
            end
            if (c == 11) begin
                chk("held_restart_rd_en_b", 32'(rd_en_b), 1);
                chk("held_restart_row_b", 32'(row_b), 0);
                start = 1'b0;
            end
            tick();
        end
        chk("held_final_busy_a", 32'(busy_a), 0);
        chk("held_final_busy_b", 32'(busy_b), 0);
        check_answers("held", exp1);

        // Reset in cycle 3 of a run, then a clean run
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        #1;
        chk("abort_rd_en_a", 32'(rd_en_a), 0);
        chk("abort_row_a", 32'(row_a), 0);
        chk("abort_busy_a", 32'(busy_a), 0);
        chk("abort_done_a", 32'(done_a), 0);
        chk("abort_rd_en_b", 32'(rd_en_b), 0);
        chk("abort_busy_b", 32'(busy_b), 0);
        chk("abort_ans_a", 32'(ans_a), 0);
        chk("abort_ans_b", 32'(ans_b), 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 12; c++) tick();
        chk("after_abort_busy_b", 32'(busy_b), 0);
        check_answers("after_abort", exp1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
